// File: rtl/fft_sched_pkg.sv
// Shared types and helpers for the FFT frame scheduler.
package fft_sched_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_OUT, DRAIN} state_e;

   localparam int FFT_N      = 16;
   localparam int CPLX_MAX_W = 32;

   // Packs {real, imag}, each w bits wide, into the low 2*w bits of the result.
   function automatic logic [2*CPLX_MAX_W-1:0] pack_cplx(
      input logic [CPLX_MAX_W-1:0] re,
      input logic [CPLX_MAX_W-1:0] im,
      input int unsigned           w
   );
      logic [2*CPLX_MAX_W-1:0] mask;
      mask = ({{CPLX_MAX_W{1'b0}}, {CPLX_MAX_W{1'b1}}}) >> (CPLX_MAX_W - w);
      return ((({{CPLX_MAX_W{1'b0}}, re}) & mask) << w) | (({{CPLX_MAX_W{1'b0}}, im}) & mask);
   endfunction

endpackage

// File: rtl/fft_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping N-1 -> 0.
module fft_rr_arbiter
   import fft_sched_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic found;
   int   j;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found   = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/fft_frame_scheduler.sv
// Buffers one frame per channel and time-shares one FFT core, re-emitting bins tagged by channel/bin.
// Define FFT_SCHED_TIMEOUT_EN to add the WAIT_OUT watchdog (parameter TIMEOUT_CYC, output err_timeout).
module fft_frame_scheduler
   import fft_sched_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int FRAME_LEN = FFT_N,
   parameter int SAMPLE_W  = 12
`ifdef FFT_SCHED_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYC = 1024
`endif
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [N_CH-1:0]              s_valid,
   input  logic [N_CH*SAMPLE_W-1:0]     s_data,
   output logic [N_CH-1:0]              s_ready,
   output logic [2*SAMPLE_W-1:0]        fft_in_x,
   output logic                         fft_in_nd,
   input  logic [2*SAMPLE_W-1:0]        fft_out_x,
   input  logic                         fft_out_nd,
   input  logic                         fft_overflow,
   output logic                         m_valid,
   output logic [2*SAMPLE_W-1:0]        m_data,
   output logic [$clog2(N_CH)-1:0]      m_ch,
   output logic [$clog2(FRAME_LEN)-1:0] m_bin,
   output logic                         m_last,
   output logic [N_CH-1:0]              drop_sticky,
   output logic                         err_frame,
   output logic                         err_overflow,
`ifdef FFT_SCHED_TIMEOUT_EN
   output logic                         err_timeout,
`endif
   input  logic                         clear_err,
   output logic                         busy
);

   localparam int CH_W  = $clog2(N_CH);
   localparam int BIN_W = $clog2(FRAME_LEN);
   localparam int WC_W  = BIN_W + 1;
   localparam int X_W   = 2 * SAMPLE_W;

   logic [SAMPLE_W-1:0] buf_mem [N_CH][FRAME_LEN];
   logic [WC_W-1:0]     wc_q [N_CH];
   logic [WC_W-1:0]     wc_d [N_CH];
   logic [N_CH-1:0]     full, gnt;
   logic [CH_W-1:0]     gnt_idx;

   state_e              state_q, state_d;
   logic [CH_W-1:0]     ptr_q, ptr_d, g_ch_q, g_ch_d;
   logic [BIN_W-1:0]    ld_cnt_q, ld_cnt_d, bin_cnt_q, bin_cnt_d;
   logic [X_W-1:0]      in_x_q, in_x_d;
   logic                in_nd_q, in_nd_d;
   logic                m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic [X_W-1:0]      m_data_q, m_data_d;
   logic [CH_W-1:0]     m_ch_q, m_ch_d;
   logic [BIN_W-1:0]    m_bin_q, m_bin_d;
   logic [N_CH-1:0]     drop_q, drop_d;
   logic                err_frame_q, err_frame_d, err_ovf_q, err_ovf_d;
   logic                release_frame, frame_err;
`ifdef FFT_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic                err_to_q, err_to_d, timeout_hit;
`endif

   function automatic logic [X_W-1:0] to_fft_word(input logic [SAMPLE_W-1:0] s);
      return X_W'(pack_cplx(CPLX_MAX_W'(s), '0, SAMPLE_W));
   endfunction

   fft_rr_arbiter #(.N(N_CH), .IDX_W(CH_W)) u_arb (
      .req     (full),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   always_comb begin
      for (int c = 0; c < N_CH; c++) full[c] = (wc_q[c] == WC_W'(FRAME_LEN));
   end

   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         wc_d[c] = wc_q[c];
         if (release_frame && g_ch_q == CH_W'(c)) wc_d[c] = '0;
         else if (s_valid[c] && !full[c])        wc_d[c] = wc_q[c] + WC_W'(1);
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      g_ch_d        = g_ch_q;
      ld_cnt_d      = ld_cnt_q;
      bin_cnt_d     = bin_cnt_q;
      in_x_d        = in_x_q;
      in_nd_d       = 1'b0;
      m_valid_d     = 1'b0;
      m_last_d      = 1'b0;
      m_data_d      = m_data_q;
      m_ch_d        = m_ch_q;
      m_bin_d       = m_bin_q;
      release_frame = 1'b0;
      frame_err     = 1'b0;
`ifdef FFT_SCHED_TIMEOUT_EN
      to_cnt_d      = '0;
      timeout_hit   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            frame_err = fft_out_nd;
            if (|gnt) begin
               g_ch_d   = gnt_idx;
               ptr_d    = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
               ld_cnt_d = '0;
               in_nd_d  = 1'b1;
               in_x_d   = to_fft_word(buf_mem[gnt_idx][0]);
               state_d  = LOAD;
            end
         end
         LOAD: begin
            frame_err = fft_out_nd;
            if (ld_cnt_q == BIN_W'(FRAME_LEN - 1)) begin
               release_frame = 1'b1;
               state_d       = WAIT_OUT;
            end else begin
               ld_cnt_d = ld_cnt_q + BIN_W'(1);
               in_nd_d  = 1'b1;
               in_x_d   = to_fft_word(buf_mem[g_ch_q][ld_cnt_q + BIN_W'(1)]);
            end
         end
         WAIT_OUT: begin
            if (fft_out_nd) begin
               m_valid_d = 1'b1;
               m_data_d  = fft_out_x;
               m_ch_d    = g_ch_q;
               m_bin_d   = '0;
               bin_cnt_d = BIN_W'(1);
               state_d   = DRAIN;
            end
`ifdef FFT_SCHED_TIMEOUT_EN
            else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
               timeout_hit = 1'b1;
               state_d     = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
`endif
         end
         DRAIN: begin
            if (fft_out_nd) begin
               m_valid_d = 1'b1;
               m_data_d  = fft_out_x;
               m_ch_d    = g_ch_q;
               m_bin_d   = bin_cnt_q;
               if (bin_cnt_q == BIN_W'(FRAME_LEN - 1)) begin
                  m_last_d = 1'b1;
                  state_d  = IDLE;
               end else begin
                  bin_cnt_d = bin_cnt_q + BIN_W'(1);
               end
            end else begin
               frame_err = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sticky flags: a set event in the same cycle as clear_err wins.
   always_comb begin
      drop_d      = (s_valid & full) | (drop_q & ~{N_CH{clear_err}});
      err_frame_d = frame_err | (err_frame_q & ~clear_err);
      err_ovf_d   = fft_overflow | (err_ovf_q & ~clear_err);
`ifdef FFT_SCHED_TIMEOUT_EN
      err_to_d    = timeout_hit | (err_to_q & ~clear_err);
`endif
   end

   // NOTE: the sample store has no reset; every word is written before the full flag lets it be read.
   always_ff @(posedge clk) begin
      for (int c = 0; c < N_CH; c++) begin
         if (s_valid[c] && !full[c]) buf_mem[c][wc_q[c][BIN_W-1:0]] <= s_data[c*SAMPLE_W +: SAMPLE_W];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < N_CH; c++) wc_q[c] <= '0;
         state_q     <= IDLE;
         ptr_q       <= '0;
         g_ch_q      <= '0;
         ld_cnt_q    <= '0;
         bin_cnt_q   <= '0;
         in_x_q      <= '0;
         in_nd_q     <= 1'b0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         m_data_q    <= '0;
         m_ch_q      <= '0;
         m_bin_q     <= '0;
         drop_q      <= '0;
         err_frame_q <= 1'b0;
         err_ovf_q   <= 1'b0;
`ifdef FFT_SCHED_TIMEOUT_EN
         to_cnt_q    <= '0;
         err_to_q    <= 1'b0;
`endif
      end else begin
         for (int c = 0; c < N_CH; c++) wc_q[c] <= wc_d[c];
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         g_ch_q      <= g_ch_d;
         ld_cnt_q    <= ld_cnt_d;
         bin_cnt_q   <= bin_cnt_d;
         in_x_q      <= in_x_d;
         in_nd_q     <= in_nd_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         m_data_q    <= m_data_d;
         m_ch_q      <= m_ch_d;
         m_bin_q     <= m_bin_d;
         drop_q      <= drop_d;
         err_frame_q <= err_frame_d;
         err_ovf_q   <= err_ovf_d;
`ifdef FFT_SCHED_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
         err_to_q    <= err_to_d;
`endif
      end
   end

   assign s_ready      = ~full;
   assign fft_in_x     = in_x_q;
   assign fft_in_nd    = in_nd_q;
   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign m_ch         = m_ch_q;
   assign m_bin        = m_bin_q;
   assign m_last       = m_last_q;
   assign drop_sticky  = drop_q;
   assign err_frame    = err_frame_q;
   assign err_overflow = err_ovf_q;
   assign busy         = (state_q != IDLE);
`ifdef FFT_SCHED_TIMEOUT_EN
   assign err_timeout  = err_to_q;
`endif

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Shares one 16-point DIT FFT core between N_CH sample channels (electrode streams).
- Buffers one frame per channel, round-robin arbitrates full frames into the FFT, streams samples with in_nd, collects the out_nd bin burst, and re-emits bins tagged with channel and bin index.
- Sits between the ADC sample front-end and the spectral post-processing.

Parameters:
- N_CH, 4, number of requesting channels (2..8).
- FRAME_LEN, 16, samples per FFT frame; must equal the FFT core size.
- SAMPLE_W, 12, sample width; the FFT word is 2*SAMPLE_W as {real, imag}.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- s_valid  in  N_CH  per-channel sample strobe.
- s_data  in  N_CH*SAMPLE_W  per-channel samples; channel c uses bits [c*SAMPLE_W +: SAMPLE_W].
- s_ready  out  N_CH  channel buffer can accept a sample.
- fft_in_x  out  2*SAMPLE_W  sample to FFT: {real = sample, imag = 0}.
- fft_in_nd  out  1  new-data strobe to FFT.
- fft_out_x  in  2*SAMPLE_W  FFT bin output.
- fft_out_nd  in  1  FFT bin valid.
- fft_overflow  in  1  FFT cannot keep up.
- m_valid  out  1  tagged bin valid.
- m_data  out  2*SAMPLE_W  bin value.
- m_ch  out  $clog2(N_CH)  source channel.
- m_bin  out  $clog2(FRAME_LEN)  bin index, in FFT output order.
- m_last  out  1  last bin of the frame.
- drop_sticky  out  N_CH  a sample was lost on that channel.
- err_frame  out  1  sticky: truncated or spurious out_nd burst.
- err_overflow  out  1  sticky: fft_overflow seen.
- clear_err  in  1  synchronous clear of all sticky flags.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0 except s_ready = all ones. Buffers empty, RR pointer = 0, state IDLE. Reset mid-frame abandons the frame; fft_in_nd drops asynchronously.
- Per-channel buffer: FRAME_LEN x SAMPLE_W, write counter wc[c].
  - s_valid && s_ready stores the sample and increments wc.
  - At wc = FRAME_LEN the buffer is full: req[c] = 1, s_ready[c] = 0.
  - s_valid while s_ready[c] = 0: sample dropped, drop_sticky[c] set.
- FSM IDLE:
  - If any req, grant the first requesting channel at or after the RR pointer (wrap N_CH-1 -> 0).
  - Latch g_ch; pointer <= g_ch+1 (mod N_CH); go to LOAD.
  - A buffer filling in the same cycle is eligible next cycle.
- FSM LOAD:
  - fft_in_nd = 1 for exactly FRAME_LEN consecutive cycles.
  - Cycle k presents buffer[g_ch][k] in natural order, registered.
  - On the last sample, buffer g_ch is released (wc = 0, s_ready = 1 next cycle). Go to WAIT_OUT.
- FSM WAIT_OUT:
  - fft_in_nd = 0.
  - First cycle with fft_out_nd = 1 goes to DRAIN and counts as bin 0.
- FSM DRAIN:
  - Each fft_out_nd cycle produces m_valid one cycle later with m_data = fft_out_x, m_ch = g_ch, m_bin = count.
  - m_last accompanies bin FRAME_LEN-1; state then returns to IDLE.
  - fft_out_nd low before FRAME_LEN bins: set err_frame, return to IDLE, m_last never issued.
- Scheduling latency:
  - A new grant is possible on the cycle after m_last.
  - Frames never overlap in the FFT.
  - Grant to first fft_in_nd is 1 cycle.
- fft_out_nd in IDLE or LOAD: ignored, err_frame set.
- fft_overflow = 1 in any state sets err_overflow.
- clear_err clears the sticky flags. If clear_err and a set event occur in the same cycle, set wins.
- No backpressure on m_*: consumer must accept every cycle.

Optional Feature:
- Macro: FFT_SCHED_TIMEOUT_EN.
- Defined:
  - Parameter TIMEOUT_CYC (default 1024) and output err_timeout are present.
  - A counter runs in WAIT_OUT. Reaching TIMEOUT_CYC with no fft_out_nd sets sticky err_timeout and returns to IDLE.
  - clear_err also clears err_timeout.
- Undefined: WAIT_OUT waits forever; no err_timeout port or counter exists.

Decomposition:
- Package fft_sched_pkg:
  - state enum {IDLE, LOAD, WAIT_OUT, DRAIN}.
  - FFT_N = 16 constant.
  - Helper for packing {real, imag}.
- One sub-module: fft_rr_arbiter (N_CH-wide round-robin, req/ptr in, one-hot grant plus index out, combinational).
- Buffers and FSM stay in the top module.

Test Plan:
- Ch0 fed 50,115,43,20,2,13,115,20,200,46,80,92,73,62,900,1 -> 16 cycles fft_in_nd = 1, fft_in_x = 0x032000, then 0x073000, ..., then 0x001000. With a model FFT producing 16 bins: m_ch = 0, m_bin 0..15, m_last on bin 15.
- All 4 channels full simultaneously -> grants in order 0,1,2,3. Then ch1 and ch3 full again with pointer at 0 -> ch1 then ch3.
- 17th sample to ch2 while its frame is queued -> drop_sticky = 4'b0100. clear_err -> 0.
- Model emits only 10 out_nd cycles -> err_frame = 1, no m_last, next frame granted normally.
- reset_n pulsed low mid-LOAD at sample 7 -> fft_in_nd = 0 immediately, s_ready = 4'hF, busy = 0.
- With FFT_SCHED_TIMEOUT_EN and TIMEOUT_CYC = 32, no out_nd -> err_timeout set on cycle 32 of WAIT_OUT, FSM back to IDLE.
